mem_issue_sched: RTL and testbench

Load/store issue scheduler that sits between instruction dispatch and the single-ported data memory. It holds up to 4 pending loads and 4 pending stores and selects one access at a time for the memory port, using oldest-first order and a same-address hazard rule. When an access completes it broadcasts a completion on the data bus, tagged so the reservation station can retire the matching entry and release its register-status counts. For loads it also writes the result to the register file.

---
 rtl/mem_issue_sched.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mem_issue_sched.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_issue_sched.sv
// Load/store issue scheduler: four load and four store entries feeding one memory port,
// oldest-first selection with a same-address store-before-load hazard rule.
//
// state  | meaning
// S_IDLE | choose the oldest eligible access, latch the memory request
// S_REQ  | mem_req held with stable address/data until mem_ack
// S_DONE | completion broadcast for one cycle, entry released at its end
module mem_issue_sched #(
  parameter int NLD = 4,
  parameter int NST = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        alloc_valid,
  input  logic        alloc_store,
  input  logic [31:0] alloc_address,
  input  logic [31:0] alloc_data,
  input  logic [4:0]  alloc_dst,
  output logic        rs_lok,
  output logic        rs_sok,
  output logic        rs_free,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [63:0] out_databus,
  output logic        write_databus,
  output logic [4:0]  out_dst,
  output logic [31:0] out_dst_data,
  output logic        write_dst
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  seq_q, seq_d;

  logic [NLD-1:0] ld_busy_q, ld_busy_d;
  logic [31:0]    ld_addr_q [NLD];
  logic [31:0]    ld_addr_d [NLD];
  logic [4:0]     ld_dst_q  [NLD];
  logic [4:0]     ld_dst_d  [NLD];
  logic [3:0]     ld_seq_q  [NLD];
  logic [3:0]     ld_seq_d  [NLD];

  logic [NST-1:0] st_busy_q, st_busy_d;
  logic [31:0]    st_addr_q [NST];
  logic [31:0]    st_addr_d [NST];
  logic [31:0]    st_data_q [NST];
  logic [31:0]    st_data_d [NST];
  logic [3:0]     st_seq_q  [NST];
  logic [3:0]     st_seq_d  [NST];

  logic        cur_store_q, cur_store_d;
  logic [1:0]  cur_idx_q, cur_idx_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        write_databus_q, write_databus_d;
  logic [63:0] out_databus_q, out_databus_d;
  logic        write_dst_q, write_dst_d;
  logic [4:0]  out_dst_q, out_dst_d;
  logic [31:0] out_dst_data_q, out_dst_data_d;
  logic        rs_lok_q, rs_lok_d;
  logic        rs_sok_q, rs_sok_d;
  logic        rs_free_q, rs_free_d;

  // Modular age: at most 8 entries live, so a forward distance of 1..7 means "a is older".
  function automatic logic older(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] diff;
    diff = b - a;
    return (diff != 4'd0) && !diff[3];
  endfunction

  logic [NLD-1:0] ld_elig;
  logic           ld_ok, st_ok, ld_free_ok, st_free_ok, first, pick_store;
  logic [1:0]     ld_pick, st_pick, ld_free_idx, st_free_idx;

  always_comb begin
    st_ok   = 1'b0;
    st_pick = 2'd0;
    for (int i = 0; i < NST; i++) begin
      first = st_busy_q[i];
      for (int j = 0; j < NST; j++)
        if (j != i && st_busy_q[j] && !older(st_seq_q[i], st_seq_q[j])) first = 1'b0;
      if (first) begin
        st_ok   = 1'b1;
        st_pick = 2'(i);
      end
    end

    for (int i = 0; i < NLD; i++) begin
      ld_elig[i] = ld_busy_q[i];
      for (int j = 0; j < NST; j++)
        if (st_busy_q[j] && st_addr_q[j] == ld_addr_q[i] && older(st_seq_q[j], ld_seq_q[i]))
          ld_elig[i] = 1'b0;
    end

    ld_ok   = 1'b0;
    ld_pick = 2'd0;
    for (int i = 0; i < NLD; i++) begin
      first = ld_elig[i];
      for (int j = 0; j < NLD; j++)
        if (j != i && ld_elig[j] && !older(ld_seq_q[i], ld_seq_q[j])) first = 1'b0;
      if (first) begin
        ld_ok   = 1'b1;
        ld_pick = 2'(i);
      end
    end

    ld_free_ok  = 1'b0;
    ld_free_idx = 2'd0;
    for (int i = NLD - 1; i >= 0; i--)
      if (!ld_busy_q[i]) begin
        ld_free_ok  = 1'b1;
        ld_free_idx = 2'(i);
      end
    st_free_ok  = 1'b0;
    st_free_idx = 2'd0;
    for (int i = NST - 1; i >= 0; i--)
      if (!st_busy_q[i]) begin
        st_free_ok  = 1'b1;
        st_free_idx = 2'(i);
      end

    pick_store = st_ok && (!ld_ok || older(st_seq_q[st_pick], ld_seq_q[ld_pick]));
  end

  always_comb begin
    state_d         = state_q;
    seq_d           = seq_q;
    ld_busy_d       = ld_busy_q;
    ld_addr_d       = ld_addr_q;
    ld_dst_d        = ld_dst_q;
    ld_seq_d        = ld_seq_q;
    st_busy_d       = st_busy_q;
    st_addr_d       = st_addr_q;
    st_data_d       = st_data_q;
    st_seq_d        = st_seq_q;
    cur_store_d     = cur_store_q;
    cur_idx_d       = cur_idx_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    write_databus_d = write_databus_q;
    out_databus_d   = out_databus_q;
    write_dst_d     = write_dst_q;
    out_dst_d       = out_dst_q;
    out_dst_data_d  = out_dst_data_q;

    // Free slots come from the pre-edge busy bits, so the entry finishing DONE is not reusable yet.
    if (alloc_valid) begin
      if (alloc_store && st_free_ok) begin
        st_busy_d[st_free_idx] = 1'b1;
        st_addr_d[st_free_idx] = alloc_address;
        st_data_d[st_free_idx] = alloc_data;
        st_seq_d[st_free_idx]  = seq_q;
        seq_d                  = seq_q + 4'd1;
      end else if (!alloc_store && ld_free_ok) begin
        ld_busy_d[ld_free_idx] = 1'b1;
        ld_addr_d[ld_free_idx] = alloc_address;
        ld_dst_d[ld_free_idx]  = alloc_dst;
        ld_seq_d[ld_free_idx]  = seq_q;
        seq_d                  = seq_q + 4'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (st_ok || ld_ok) begin
          cur_store_d = pick_store;
          cur_idx_d   = pick_store ? st_pick : ld_pick;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_store;
          mem_addr_d  = pick_store ? st_addr_q[st_pick] : ld_addr_q[ld_pick];
          mem_wdata_d = pick_store ? st_data_q[st_pick] : 32'h0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          mem_req_d       = 1'b0;
          write_databus_d = 1'b1;
          out_databus_d   = {(cur_store_q ? 16'h0002 : 16'h0001), 16'h0000, mem_addr_q};
          if (!cur_store_q) begin
            write_dst_d    = 1'b1;
            out_dst_d      = ld_dst_q[cur_idx_q];
            out_dst_data_d = mem_rdata;
          end
          state_d = S_DONE;
        end
      end
      default: begin
        write_databus_d = 1'b0;
        write_dst_d     = 1'b0;
        if (cur_store_q) st_busy_d[cur_idx_q] = 1'b0;
        else             ld_busy_d[cur_idx_q] = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    rs_lok_d  = ~&ld_busy_d;
    rs_sok_d  = ~&st_busy_d;
    rs_free_d = ~|ld_busy_d && ~|st_busy_d && (state_d == S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      seq_q           <= 4'd0;
      ld_busy_q       <= '0;
      ld_addr_q       <= '{default: '0};
      ld_dst_q        <= '{default: '0};
      ld_seq_q        <= '{default: '0};
      st_busy_q       <= '0;
      st_addr_q       <= '{default: '0};
      st_data_q       <= '{default: '0};
      st_seq_q        <= '{default: '0};
      cur_store_q     <= 1'b0;
      cur_idx_q       <= 2'd0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= 32'h0;
      mem_wdata_q     <= 32'h0;
      write_databus_q <= 1'b0;
      out_databus_q   <= 64'h0;
      write_dst_q     <= 1'b0;
      out_dst_q       <= 5'd0;
      out_dst_data_q  <= 32'h0;
      rs_lok_q        <= 1'b1;
      rs_sok_q        <= 1'b1;
      rs_free_q       <= 1'b1;
    end else begin
      state_q         <= state_d;
      seq_q           <= seq_d;
      ld_busy_q       <= ld_busy_d;
      ld_addr_q       <= ld_addr_d;
      ld_dst_q        <= ld_dst_d;
      ld_seq_q        <= ld_seq_d;
      st_busy_q       <= st_busy_d;
      st_addr_q       <= st_addr_d;
      st_data_q       <= st_data_d;
      st_seq_q        <= st_seq_d;
      cur_store_q     <= cur_store_d;
      cur_idx_q       <= cur_idx_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      write_databus_q <= write_databus_d;
      out_databus_q   <= out_databus_d;
      write_dst_q     <= write_dst_d;
      out_dst_q       <= out_dst_d;
      out_dst_data_q  <= out_dst_data_d;
      rs_lok_q        <= rs_lok_d;
      rs_sok_q        <= rs_sok_d;
      rs_free_q       <= rs_free_d;
    end
  end

  assign rs_lok        = rs_lok_q;
  assign rs_sok        = rs_sok_q;
  assign rs_free       = rs_free_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign write_databus = write_databus_q;
  assign out_databus   = out_databus_q;
  assign write_dst     = write_dst_q;
  assign out_dst       = out_dst_q;
  assign out_dst_data  = out_dst_data_q;

endmodule

// File: tb/tb_mem_issue_sched.sv
// Bench for mem_issue_sched: directed scenarios plus random traffic, checked every cycle
// against an order-number model of pending accesses.
module tb_mem_issue_sched;

  logic        clock = 1'b0;
  logic        resetn;
  logic        alloc_valid, alloc_store;
  logic [31:0] alloc_address, alloc_data;
  logic [4:0]  alloc_dst;
  logic        rs_lok, rs_sok, rs_free;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [63:0] out_databus;
  logic        write_databus;
  logic [4:0]  out_dst;
  logic [31:0] out_dst_data;
  logic        write_dst;

  always #5 clock = ~clock;

  mem_issue_sched dut (
    .clock(clock), .resetn(resetn),
    .alloc_valid(alloc_valid), .alloc_store(alloc_store), .alloc_address(alloc_address),
    .alloc_data(alloc_data), .alloc_dst(alloc_dst),
    .rs_lok(rs_lok), .rs_sok(rs_sok), .rs_free(rs_free),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_databus(out_databus), .write_databus(write_databus),
    .out_dst(out_dst), .out_dst_data(out_dst_data), .write_dst(write_dst)
  );

  typedef struct {
    bit          st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  dst;
    int          ord;
  } ent_t;

  ent_t        mlist[$];
  ent_t        cur;
  int          phase;       // 0 idle, 1 request outstanding, 2 completion cycle
  int          next_ord, n_acc;
  logic [31:0] cur_rdata;
  logic [31:0] log_addr[$];
  bit          log_st[$];
  logic [63:0] last_db;
  logic [4:0]  last_dst;
  logic [31:0] last_dd;

  bit stall, spur, force_ack, rdata_force;
  int ack_wait, req_age;
  int n_checks, n_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Oldest store vs. oldest load with no older same-address store; smaller order number wins.
  function automatic int pick();
    int bs, bl;
    bit ok;
    bs = -1;
    bl = -1;
    foreach (mlist[i]) begin
      if (mlist[i].st) begin
        if (bs < 0 || mlist[i].ord < mlist[bs].ord) bs = i;
      end else begin
        ok = 1'b1;
        foreach (mlist[k])
          if (mlist[k].st && mlist[k].ord < mlist[i].ord && mlist[k].addr == mlist[i].addr) ok = 1'b0;
        if (ok && (bl < 0 || mlist[i].ord < mlist[bl].ord)) bl = i;
      end
    end
    if (bs < 0) return bl;
    if (bl < 0) return bs;
    return (mlist[bs].ord < mlist[bl].ord) ? bs : bl;
  endfunction

  task automatic tick();
    bit   acc, done_now;
    int   k, nl, ns;
    ent_t e;
    acc = 1'b0;
    done_now = 1'b0;
    @(posedge clock);
    if (!resetn) begin
      mlist.delete();
      phase = 0;
    end else begin
      if (alloc_valid) begin
        nl = 0;
        ns = 0;
        foreach (mlist[i]) if (mlist[i].st) ns++; else nl++;
        acc    = alloc_store ? (ns < 4) : (nl < 4);
        e.st   = alloc_store;
        e.addr = alloc_address;
        e.data = alloc_data;
        e.dst  = alloc_dst;
        e.ord  = next_ord;
      end
      case (phase)
        0: begin
          k = pick();
          if (k >= 0) begin
            cur = mlist[k];
            phase = 1;
          end
        end
        1: if (mem_ack) begin
          phase = 2;
          done_now = 1'b1;
          cur_rdata = mem_rdata;
        end
        default: begin
          for (int i = mlist.size() - 1; i >= 0; i--)
            if (mlist[i].ord == cur.ord) mlist.delete(i);
          phase = 0;
        end
      endcase
      if (acc) begin
        mlist.push_back(e);
        next_ord++;
        n_acc++;
      end
    end
    #1;
    nl = 0;
    ns = 0;
    foreach (mlist[i]) if (mlist[i].st) ns++; else nl++;
    chk("mem_req", mem_req, phase == 1);
    if (phase == 1) begin
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_we", mem_we, cur.st);
      if (cur.st) chk("mem_wdata", mem_wdata, cur.data);
    end
    chk("write_databus", write_databus, done_now);
    chk("write_dst", write_dst, done_now && !cur.st);
    if (done_now) begin
      chk("out_databus", out_databus, {(cur.st ? 16'h0002 : 16'h0001), 16'h0000, cur.addr});
      if (!cur.st) begin
        chk("out_dst", out_dst, cur.dst);
        chk("out_dst_data", out_dst_data, cur_rdata);
      end
      log_addr.push_back(cur.addr);
      log_st.push_back(cur.st);
      last_db  = out_databus;
      last_dst = out_dst;
      last_dd  = out_dst_data;
    end
    chk("rs_lok", rs_lok, nl < 4);
    chk("rs_sok", rs_sok, ns < 4);
    chk("rs_free", rs_free, (nl + ns == 0) && phase == 0);

    alloc_valid = 1'b0;
    if (mem_req) req_age++; else req_age = 0;
    mem_ack = force_ack || (!stall && mem_req && req_age > ack_wait) ||
              (spur && !mem_req && $urandom_range(0, 1) == 1);
    mem_rdata = rdata_force ? 32'hDEADBEEF : $urandom;
  endtask

  task automatic alloc(input bit st, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] dst);
    alloc_valid   = 1'b1;
    alloc_store   = st;
    alloc_address = addr;
    alloc_data    = data;
    alloc_dst     = dst;
    tick();
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!(rs_free === 1'b1 && mlist.size() == 0 && phase == 0) && n < max_cycles) begin
      tick();
      n++;
    end
    chk(tag, rs_free, 1'b1);
  endtask

  initial begin
    int base;
    resetn = 1'b0;
    alloc_valid = 1'b0;
    alloc_store = 1'b0;
    alloc_address = '0;
    alloc_data = '0;
    alloc_dst = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    stall = 1'b0;
    spur = 1'b0;
    force_ack = 1'b0;
    rdata_force = 1'b0;
    ack_wait = 0;
    req_age = 0;
    phase = 0;
    next_ord = 0;
    n_acc = 0;
    n_checks = 0;
    n_pass = 0;

    // Reset and idle
    tick();
    tick();
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_out_databus", out_databus, 64'h0);
    chk("rst_out_dst", out_dst, 5'd0);
    chk("rst_out_dst_data", out_dst_data, 32'h0);
    resetn = 1'b1;
    repeat (5) tick();

    // Single load, ack two cycles later than zero-wait
    ack_wait = 2;
    rdata_force = 1'b1;
    log_addr.delete();
    log_st.delete();
    alloc(1'b0, 32'h10, 32'h0, 5'd5);
    drain("single_drain", 20);
    chk("single_count", log_addr.size(), 1);
    chk("single_db", last_db, 64'h0001_0000_0000_0010);
    chk("single_dst", last_dst, 5'd5);
    chk("single_data", last_dd, 32'hDEADBEEF);
    rdata_force = 1'b0;
    ack_wait = 0;

    // Same-address hazard: store first, then the dependent load, then the later load
    log_addr.delete();
    log_st.delete();
    stall = 1'b1;
    alloc(1'b1, 32'h20, 32'hCAFE_0001, 5'd0);
    alloc(1'b0, 32'h20, 32'h0, 5'd7);
    chk("hz_store_first", mem_we, 1'b1);
    alloc(1'b0, 32'h24, 32'h0, 5'd8);
    repeat (3) tick();
    stall = 1'b0;
    drain("hz_drain", 40);
    chk("hz_count", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      chk("hz_0_addr", log_addr[0], 32'h20);
      chk("hz_0_st", log_st[0], 1'b1);
      chk("hz_1_addr", log_addr[1], 32'h20);
      chk("hz_1_st", log_st[1], 1'b0);
      chk("hz_2_addr", log_addr[2], 32'h24);
    end

    // Full load class: fifth allocate dropped
    log_addr.delete();
    log_st.delete();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) alloc(1'b0, 32'h100 + 32'(i * 4), 32'h0, 5'(i + 1));
    chk("full_lok", rs_lok, 1'b0);
    alloc(1'b0, 32'h200, 32'h0, 5'd9);
    chk("full_lok_after_drop", rs_lok, 1'b0);
    stall = 1'b0;
    drain("full_drain", 60);
    chk("full_count", log_addr.size(), 4);

    // Twenty mixed operations across the sequence wrap
    log_addr.delete();
    log_st.delete();
    base = n_acc;
    for (int i = 0; i < 20; i++) begin
      alloc($urandom_range(0, 1) == 1, 32'h80 + 32'($urandom_range(0, 2) * 4), $urandom,
            5'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 2)) tick();
    end
    drain("wrap_drain", 200);
    chk("wrap_count", log_addr.size(), n_acc - base);

    // Random traffic with varying memory latency and stray acks
    log_addr.delete();
    log_st.delete();
    base = n_acc;
    spur = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ack_wait = $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 6)
        alloc($urandom_range(0, 1) == 1, 32'h40 + 32'($urandom_range(0, 3) * 4), $urandom,
              5'($urandom_range(0, 31)));
      else
        tick();
    end
    spur = 1'b0;
    drain("rand_drain", 400);
    chk("rand_count", log_addr.size(), n_acc - base);

    // Reset while a request is outstanding; a late ack must be ignored
    ack_wait = 0;
    stall = 1'b1;
    alloc(1'b0, 32'h300, 32'h0, 5'd3);
    alloc(1'b1, 32'h304, 32'h1234, 5'd0);
    chk("mid_req_pending", mem_req, 1'b1);
    resetn = 1'b0;
    tick();
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_lok", rs_lok, 1'b1);
    chk("mid_rst_sok", rs_sok, 1'b1);
    chk("mid_rst_free", rs_free, 1'b1);
    resetn = 1'b1;
    stall = 1'b0;
    force_ack = 1'b1;
    mem_ack = 1'b1;
    repeat (3) begin
      tick();
      chk("late_ack_no_strobe", write_databus, 1'b0);
    end
    force_ack = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
